// File: rtl/pixel_write_sink_if.sv
// Pixel write sink bus: drawer pixel stream in, framebuffer write port and status out.
// The master side is the drawer/framebuffer environment; the slave side is the sink itself.
interface pixel_write_sink_if #(
    parameter int ADDR_W = 17
) ();
    logic [8:0]        inX;
    logic [7:0]        inY;
    logic [11:0]       inColor;
    logic              inWriteEn;
    logic              clear_req;
    logic              fb_stall;
    logic [ADDR_W-1:0] fb_addr;
    logic [11:0]       fb_data;
    logic              fb_we;
    logic              full;
    logic              overflow;
    logic              clear_busy;
    logic              clear_done;

    modport slave (
        input  inX, inY, inColor, inWriteEn, clear_req, fb_stall,
        output fb_addr, fb_data, fb_we, full, overflow, clear_busy, clear_done
    );

    modport master (
        output inX, inY, inColor, inWriteEn, clear_req, fb_stall,
        input  fb_addr, fb_data, fb_we, full, overflow, clear_busy, clear_done
    );
endinterface

// File: rtl/pixel_write_sink.sv
// pixel_write_sink: buffers drawer pixel writes in a FIFO, clips off-screen pixels,
// converts (x,y) to a linear framebuffer address and issues stall-aware writes.
// Also performs a full-screen clear on request.
// Optional feature macro: PIXEL_SINK_TRANSPARENT_EN (drop pixels whose colour equals
// TRANSPARENT at push time; clear writes are never affected).
module pixel_write_sink #(
    parameter int          SCREEN_W    = 320,
    parameter int          SCREEN_H    = 240,
    parameter int          DEPTH       = 16,
    parameter int          ADDR_W      = 17,
    parameter logic [11:0] CLEAR_COLOR = 12'h000,
    parameter logic [11:0] TRANSPARENT = 12'hF0F
) (
    input  logic                clock,
    input  logic                resetn,
    pixel_write_sink_if.slave   bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] TOTAL     = ADDR_W'(SCREEN_W * SCREEN_H);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SCREEN_W * SCREEN_H - 1);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_CLEAR = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // FIFO storage (data only, never reset; pointers define validity)
    logic [8:0]  mem_x_q [DEPTH];
    logic [7:0]  mem_y_q [DEPTH];
    logic [11:0] mem_c_q [DEPTH];

    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q, count_d;
    logic [1:0]        state_q, state_d;
    logic              clear_pend_q, clear_pend_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic [11:0]       fb_data_q, fb_data_d;
    logic              overflow_q, overflow_d;

    logic              in_bounds, key_drop, candidate;
    logic              fifo_full, fifo_empty, slot_free;
    logic              push, pop, last_commit;
    logic [ADDR_W-1:0] pop_addr;

`ifdef PIXEL_SINK_TRANSPARENT_EN
    assign key_drop = (bus.inColor == TRANSPARENT);
`else
    // Colour key exists as a parameter but never suppresses a pixel in this build.
    assign key_drop = 1'b0 && (bus.inColor == TRANSPARENT);
`endif

    assign in_bounds  = (bus.inX < 9'(SCREEN_W)) && (bus.inY < 8'(SCREEN_H));
    assign candidate  = bus.inWriteEn && in_bounds && !key_drop;
    assign fifo_full  = (count_q == CW'(DEPTH));
    assign fifo_empty = (count_q == '0);
    // Output slot can take new data if it is empty or its current write commits now.
    assign slot_free  = !fb_we_q || !bus.fb_stall;
    // FIFO is held during a clear; draining resumes in the done cycle.
    assign pop        = (state_q != S_CLEAR) && slot_free && !fifo_empty;
    // A pop on the same edge frees a slot for a push into a full FIFO.
    assign push       = candidate && (!fifo_full || pop);
    assign pop_addr   = ADDR_W'(mem_y_q[rd_ptr_q]) * ADDR_W'(SCREEN_W)
                      + ADDR_W'(mem_x_q[rd_ptr_q]);
    assign last_commit = (state_q == S_CLEAR) && fb_we_q && !bus.fb_stall
                      && (fb_addr_q == LAST_ADDR);

    // Next-state logic for FSM, clear address, output slot and sticky overflow.
    always_comb begin
        state_d      = state_q;
        clear_pend_d = clear_pend_q;
        clr_addr_d   = clr_addr_q;
        fb_we_d      = fb_we_q;
        fb_addr_d    = fb_addr_q;
        fb_data_d    = fb_data_q;
        overflow_d   = overflow_q | (candidate && fifo_full && !pop);
        count_d      = count_q;

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (slot_free) begin
            fb_we_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                clear_pend_d = clear_pend_q | bus.clear_req;
                if (pop) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = pop_addr;
                    fb_data_d = mem_c_q[rd_ptr_q];
                end else if (clear_pend_q && fifo_empty && slot_free) begin
                    state_d    = S_CLEAR;
                    clr_addr_d = '0;
                end
            end
            S_CLEAR: begin
                if (slot_free && (clr_addr_q != TOTAL)) begin
                    fb_we_d    = 1'b1;
                    fb_addr_d  = clr_addr_q;
                    fb_data_d  = CLEAR_COLOR;
                    clr_addr_d = clr_addr_q + ADDR_W'(1);
                end
                if (last_commit) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                clear_pend_d = 1'b0;
                state_d      = S_RUN;
                if (pop) begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = pop_addr;
                    fb_data_d = mem_c_q[rd_ptr_q];
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q      <= S_RUN;
            clear_pend_q <= 1'b0;
            clr_addr_q   <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            fb_we_q      <= 1'b0;
            fb_addr_q    <= '0;
            fb_data_q    <= '0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clear_pend_q <= clear_pend_d;
            clr_addr_q   <= clr_addr_d;
            count_q      <= count_d;
            fb_we_q      <= fb_we_d;
            fb_addr_q    <= fb_addr_d;
            fb_data_q    <= fb_data_d;
            overflow_q   <= overflow_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
        end
    end

    // FIFO storage write; pointers alone decide which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_x_q[wr_ptr_q] <= bus.inX;
            mem_y_q[wr_ptr_q] <= bus.inY;
            mem_c_q[wr_ptr_q] <= bus.inColor;
        end
    end

    assign bus.fb_we      = fb_we_q;
    assign bus.fb_addr    = fb_addr_q;
    assign bus.fb_data    = fb_data_q;
    assign bus.full       = fifo_full;
    assign bus.overflow   = overflow_q;
    assign bus.clear_busy = (state_q == S_CLEAR);
    assign bus.clear_done = (state_q == S_DONE);

endmodule

// File: tb/tb_pixel_write_sink.sv
// Self-checking bench for pixel_write_sink: reset, single write, clipping, randomized
// streaming with stalls, FIFO overflow, full-screen clear, reset during clear, colour key.
module tb_pixel_write_sink;
    localparam int SW    = 320;
    localparam int SH    = 240;
    localparam int DEPTH = 16;
    localparam int AW    = 17;
    localparam int NPIX  = SW * SH;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    pixel_write_sink_if #(.ADDR_W(AW)) bus ();

    pixel_write_sink #(
        .SCREEN_W(SW), .SCREEN_H(SH), .DEPTH(DEPTH), .ADDR_W(AW),
        .CLEAR_COLOR(12'h000), .TRANSPARENT(12'hF0F)
    ) dut (
        .clock (clock),
        .resetn(resetn),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Commit log and monitor statistics
    logic [AW+11:0] got_q[$];
    int             done_pulses = 0;
    int             stab_bad    = 0;
    logic           mon_en      = 1'b0;
    logic           prev_hold   = 1'b0;
    logic [AW-1:0]  prev_addr   = '0;
    logic [11:0]    prev_data   = '0;

    // Sample mid-cycle: values seen here are what the next rising edge acts on.
    always @(negedge clock) begin
        if (mon_en) begin
            if (prev_hold && (bus.fb_we !== 1'b1 || bus.fb_addr !== prev_addr ||
                              bus.fb_data !== prev_data))
                stab_bad <= stab_bad + 1;
            if (bus.fb_we === 1'b1 && bus.fb_stall === 1'b0)
                got_q.push_back({bus.fb_addr, bus.fb_data});
            if (bus.clear_done === 1'b1)
                done_pulses <= done_pulses + 1;
        end
        prev_hold <= mon_en && (bus.fb_we === 1'b1) && (bus.fb_stall === 1'b1);
        prev_addr <= bus.fb_addr;
        prev_data <= bus.fb_data;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [AW+11:0] exp_entry(input int x, input int y, input logic [11:0] c);
        int a;
        a = y * SW + x;
        return {a[AW-1:0], c};
    endfunction

    function automatic bit key_dropped(input logic [11:0] c);
`ifdef PIXEL_SINK_TRANSPARENT_EN
        return c == 12'hF0F;
`else
        return 1'b0;
`endif
    endfunction

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got=%0b want=0", bus.fb_we); end
        checks++; if (bus.fb_addr !== '0) begin errors++; $display("FAIL reset_fb_addr got=%0d want=0", bus.fb_addr); end
        checks++; if (bus.fb_data !== 12'h000) begin errors++; $display("FAIL reset_fb_data got=%h want=000", bus.fb_data); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got=%0b want=0", bus.full); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b want=0", bus.overflow); end
        checks++; if (bus.clear_busy !== 1'b0 || bus.clear_done !== 1'b0) begin
            errors++; $display("FAIL reset_clear_flags got=%0b%0b want=00", bus.clear_busy, bus.clear_done); end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bus.inX = 9'd10; bus.inY = 8'd20; bus.inColor = 12'hABC; bus.inWriteEn = 1'b1;
        tick();
        bus.inWriteEn = 1'b0;
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL single_early_we got=%0b want=0", bus.fb_we); end
        tick();
        checks++; if (bus.fb_we !== 1'b1) begin errors++; $display("FAIL single_we got=%0b want=1", bus.fb_we); end
        checks++; if (bus.fb_addr !== 17'd6410) begin errors++; $display("FAIL single_addr got=%0d want=6410", bus.fb_addr); end
        checks++; if (bus.fb_data !== 12'hABC) begin errors++; $display("FAIL single_data got=%h want=abc", bus.fb_data); end
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL single_we_release got=%0b want=0", bus.fb_we); end
    endtask

    task automatic test_offscreen();
        int we_seen;
        we_seen = 0;
        bus.inX = 9'd320; bus.inY = 8'd5; bus.inColor = 12'h123; bus.inWriteEn = 1'b1;
        tick();
        bus.inX = 9'd5; bus.inY = 8'd240;
        tick();
        bus.inX = 9'd511; bus.inY = 8'd255;
        tick();
        bus.inWriteEn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.fb_we === 1'b1) we_seen++;
            tick();
        end
        checks++; if (we_seen != 0) begin errors++; $display("FAIL offscreen_writes got=%0d want=0", we_seen); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL offscreen_overflow got=%0b want=0", bus.overflow); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL offscreen_full got=%0b want=0", bus.full); end
    endtask

    task automatic test_random_stream();
        logic [AW+11:0] exp_q[$];
        int base, s0, x, y, waited, busy_seen;
        logic [11:0] c;
        base = got_q.size();
        s0 = stab_bad;
        busy_seen = 0;
        for (int i = 0; i < 600; i++) begin
            bus.fb_stall = ($urandom_range(0, 3) == 0);
            bus.inWriteEn = 1'b0;
            if (bus.full === 1'b0 && $urandom_range(0, 1) == 1) begin
                x = $urandom_range(0, SW + 15);
                y = $urandom_range(0, SH + 15);
                c = ($urandom_range(0, 9) == 0) ? 12'hF0F : 12'($urandom);
                bus.inX = 9'(x); bus.inY = 8'(y); bus.inColor = c; bus.inWriteEn = 1'b1;
                if (x < SW && y < SH && !key_dropped(c))
                    exp_q.push_back(exp_entry(x, y, c));
            end
            if (bus.clear_busy === 1'b1) busy_seen++;
            tick();
        end
        bus.inWriteEn = 1'b0;
        bus.fb_stall = 1'b0;
        waited = 0;
        while ((got_q.size() - base < exp_q.size() || bus.fb_we === 1'b1) && waited < 100) begin
            tick();
            waited++;
        end
        tick();
        checks++; if (got_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL random_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL random_write[%0d] got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (stab_bad != s0) begin errors++; $display("FAIL random_stall_hold got=%0d want=%0d", stab_bad, s0); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL random_overflow got=%0b want=0", bus.overflow); end
        checks++; if (busy_seen != 0) begin errors++; $display("FAIL random_clear_busy got=%0d want=0", busy_seen); end
    endtask

    task automatic test_stall_overflow();
        logic [AW+11:0] exp_q[$];
        int base, s0, waited;
        logic [11:0] c;
        base = got_q.size();
        s0 = stab_bad;
        bus.fb_stall = 1'b1;
        // With the output slot empty and the stall held, DEPTH+1 pixels fit; the rest drop.
        for (int i = 0; i < DEPTH + 2; i++) begin
            c = 12'(i * 12'h111 + 5);
            bus.inX = 9'(i * 7 + 1); bus.inY = 8'(i + 3); bus.inColor = c; bus.inWriteEn = 1'b1;
            if (i < DEPTH + 1) exp_q.push_back(exp_entry(i * 7 + 1, i + 3, c));
            tick();
        end
        bus.inWriteEn = 1'b0;
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL stall_full got=%0b want=1", bus.full); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow got=%0b want=1", bus.overflow); end
        checks++; if (bus.fb_we !== 1'b1 || {bus.fb_addr, bus.fb_data} !== exp_q[0]) begin
            errors++; $display("FAIL stall_slot got=%0b/%h want=1/%h", bus.fb_we, {bus.fb_addr, bus.fb_data}, exp_q[0]); end
        for (int i = 0; i < 5; i++) tick();
        bus.fb_stall = 1'b0;
        waited = 0;
        while ((got_q.size() - base < exp_q.size() || bus.fb_we === 1'b1) && waited < 60) begin
            tick();
            waited++;
        end
        tick();
        checks++; if (got_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL stall_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL stall_write[%0d] got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (stab_bad != s0) begin errors++; $display("FAIL stall_hold got=%0d want=%0d", stab_bad, s0); end
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL stall_full_after got=%0b want=0", bus.full); end
        checks++; if (bus.overflow !== 1'b1) begin errors++; $display("FAIL stall_overflow_sticky got=%0b want=1", bus.overflow); end
    endtask

    task automatic test_clear();
        int base, d0, cyc, bad, first_bad, busy_cycles;
        bit done_seen;
        logic [AW+11:0] pix;
        base = got_q.size();
        d0 = done_pulses;
        pix = exp_entry(100, 200, 12'h5A5);
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        cyc = 0;
        busy_cycles = 0;
        done_seen = 1'b0;
        while (!done_seen && cyc < 80000) begin
            if (bus.clear_busy === 1'b1) busy_cycles++;
            if (busy_cycles == 50) begin
                bus.inX = 9'd100; bus.inY = 8'd200; bus.inColor = 12'h5A5; bus.inWriteEn = 1'b1;
                bus.clear_req = 1'b1;
            end else begin
                bus.inWriteEn = 1'b0;
                bus.clear_req = 1'b0;
            end
            if (bus.clear_done === 1'b1) done_seen = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        bus.inWriteEn = 1'b0;
        bus.clear_req = 1'b0;
        checks++; if (!done_seen) begin errors++; $display("FAIL clear_done_timeout got=0 want=1 after %0d cycles", cyc); end
        checks++; if (busy_cycles < NPIX) begin errors++; $display("FAIL clear_busy_len got=%0d want>=%0d", busy_cycles, NPIX); end
        checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL clear_busy_in_done got=%0b want=0", bus.clear_busy); end
        tick();
        checks++; if (bus.fb_we !== 1'b1 || {bus.fb_addr, bus.fb_data} !== pix) begin
            errors++; $display("FAIL clear_next_pixel got=%0b/%h want=1/%h", bus.fb_we, {bus.fb_addr, bus.fb_data}, pix); end
        for (int i = 0; i < 10; i++) tick();
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < NPIX && base + i < got_q.size(); i++) begin
            if (got_q[base + i] !== {17'(i), 12'h000}) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL clear_writes got=%0d bad (first at %0d) want=0", bad, first_bad); end
        checks++; if (got_q.size() - base != NPIX + 1) begin
            errors++; $display("FAIL clear_total got=%0d want=%0d", got_q.size() - base, NPIX + 1); end
        if (got_q.size() - base >= NPIX + 1) begin
            checks++; if (got_q[base + NPIX] !== pix) begin
                errors++; $display("FAIL clear_pixel_after got=%h want=%h", got_q[base + NPIX], pix); end
        end
        checks++; if (done_pulses - d0 != 1) begin errors++; $display("FAIL clear_done_pulses got=%0d want=1", done_pulses - d0); end
        checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL clear_no_restart got=%0b want=0", bus.clear_busy); end
    endtask

    task automatic test_reset_mid_clear();
        int cyc, base, d0, we_seen;
        bit hit;
        bus.clear_req = 1'b1;
        tick();
        bus.clear_req = 1'b0;
        cyc = 0;
        hit = 1'b0;
        while (!hit && cyc < 3000) begin
            if (bus.fb_we === 1'b1 && bus.fb_addr === 17'd1000 && bus.clear_busy === 1'b1) hit = 1'b1;
            else begin
                tick();
                cyc++;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midclear_reach got=0 want=1 after %0d cycles", cyc); end
        resetn = 1'b0;
        tick();
        checks++; if (bus.fb_we !== 1'b0) begin errors++; $display("FAIL midclear_we got=%0b want=0", bus.fb_we); end
        checks++; if (bus.clear_busy !== 1'b0) begin errors++; $display("FAIL midclear_busy got=%0b want=0", bus.clear_busy); end
        checks++; if (bus.clear_done !== 1'b0) begin errors++; $display("FAIL midclear_done got=%0b want=0", bus.clear_done); end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL midclear_overflow got=%0b want=0", bus.overflow); end
        resetn = 1'b1;
        base = got_q.size();
        d0 = done_pulses;
        we_seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.fb_we === 1'b1 || bus.clear_busy === 1'b1) we_seen++;
        end
        checks++; if (we_seen != 0 || got_q.size() != base) begin
            errors++; $display("FAIL midclear_quiet got=%0d/%0d want=0/0", we_seen, got_q.size() - base); end
        checks++; if (done_pulses != d0) begin errors++; $display("FAIL midclear_no_done got=%0d want=0", done_pulses - d0); end
    endtask

    task automatic test_transparent();
        logic [AW+11:0] exp_q[$];
        int base;
        base = got_q.size();
        bus.inX = 9'd1; bus.inY = 8'd1; bus.inColor = 12'hF0F; bus.inWriteEn = 1'b1;
        if (!key_dropped(12'hF0F)) exp_q.push_back(exp_entry(1, 1, 12'hF0F));
        tick();
        bus.inX = 9'd2; bus.inColor = 12'hF0E;
        exp_q.push_back(exp_entry(2, 1, 12'hF0E));
        tick();
        bus.inWriteEn = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        checks++; if (got_q.size() - base != exp_q.size()) begin
            errors++; $display("FAIL key_count got=%0d want=%0d", got_q.size() - base, exp_q.size()); end
        for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++) begin
            checks++; if (got_q[base + i] !== exp_q[i]) begin
                errors++; $display("FAIL key_write[%0d] got=%h want=%h", i, got_q[base + i], exp_q[i]); end
        end
        checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL key_overflow got=%0b want=0", bus.overflow); end
    endtask

    initial begin
        bus.inX = '0; bus.inY = '0; bus.inColor = '0; bus.inWriteEn = 1'b0;
        bus.clear_req = 1'b0; bus.fb_stall = 1'b0;
        tick();
        test_reset();
        mon_en = 1'b1;
        test_single();
        test_offscreen();
        test_random_stream();
        test_stall_overflow();
        test_clear();
        test_reset_mid_clear();
        test_transparent();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
